// File: rtl/spn_round_ctrl.sv
// Iterative 16-bit SPN cipher controller: one round per clock,
// key schedule taken as sliding 16-bit windows of a 32-bit key.

module spn_round (
    input  logic [15:0] data_in,
    input  logic [15:0] rk,
    input  logic        mode,
    output logic [15:0] data_out
);

    function automatic logic [3:0] sbox(input logic [3:0] x);
        logic [3:0] y;
        unique case (x)
            4'h0: y = 4'hC;  4'h1: y = 4'h5;  4'h2: y = 4'h6;  4'h3: y = 4'hB;
            4'h4: y = 4'h9;  4'h5: y = 4'h0;  4'h6: y = 4'hA;  4'h7: y = 4'hD;
            4'h8: y = 4'h3;  4'h9: y = 4'hE;  4'hA: y = 4'hF;  4'hB: y = 4'h8;
            4'hC: y = 4'h4;  4'hD: y = 4'h7;  4'hE: y = 4'h1;  4'hF: y = 4'h2;
            default: y = 4'h0;
        endcase
        return y;
    endfunction

    function automatic logic [3:0] isbox(input logic [3:0] x);
        logic [3:0] y;
        unique case (x)
            4'h0: y = 4'h5;  4'h1: y = 4'hE;  4'h2: y = 4'hF;  4'h3: y = 4'h8;
            4'h4: y = 4'hC;  4'h5: y = 4'h1;  4'h6: y = 4'h2;  4'h7: y = 4'hD;
            4'h8: y = 4'hB;  4'h9: y = 4'h4;  4'hA: y = 4'h6;  4'hB: y = 4'h3;
            4'hC: y = 4'h0;  4'hD: y = 4'h7;  4'hE: y = 4'h9;  4'hF: y = 4'hA;
            default: y = 4'h0;
        endcase
        return y;
    endfunction

    // Nibble/bit transpose; it is its own inverse.
    function automatic logic [15:0] perm(input logic [15:0] x);
        logic [15:0] y;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                y[4*i+j] = x[4*j+i];
        return y;
    endfunction

    logic [15:0] enc_s;
    logic [15:0] dec_s;
    logic [15:0] enc_x;
    logic [15:0] dec_p;

    always_comb begin
        enc_x = data_in ^ rk;
        dec_p = perm(data_in);
        enc_s = '0;
        dec_s = '0;
        for (int n = 0; n < 4; n++) begin
            enc_s[4*n +: 4] = sbox(enc_x[4*n +: 4]);
            dec_s[4*n +: 4] = isbox(dec_p[4*n +: 4]);
        end
        data_out = mode ? (dec_s ^ rk) : perm(enc_s);
    end

endmodule

module spn_round_ctrl #(
    parameter int NUM_ROUNDS = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] data_in,
    input  logic [31:0] key,
    input  logic        mode,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] data_out
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} st_t;

    localparam logic [1:0] LAST = 2'(NUM_ROUNDS - 1);

    st_t         st_q, st_d;
    logic [15:0] state_q, state_d;
    logic [31:0] key_q, key_d;
    logic        mode_q, mode_d;
    logic [1:0]  cnt_q, cnt_d;
    logic        in_ready_q, in_ready_d;
    logic        out_valid_q, out_valid_d;

    logic [1:0]  ridx;
    logic [15:0] rk;
    logic [15:0] round_out;

    // Decrypt walks the key windows in reverse order.
    always_comb begin
        ridx = mode_q ? (LAST - cnt_q) : cnt_q;
        unique case (ridx)
            2'd0: rk = key_q[31:16];
            2'd1: rk = key_q[27:12];
            2'd2: rk = key_q[23:8];
            2'd3: rk = key_q[19:4];
            default: rk = key_q[31:16];
        endcase
    end

    spn_round u_round (
        .data_in  (state_q),
        .rk       (rk),
        .mode     (mode_q),
        .data_out (round_out)
    );

    always_comb begin
        st_d        = st_q;
        state_d     = state_q;
        key_d       = key_q;
        mode_d      = mode_q;
        cnt_d       = cnt_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        unique case (st_q)
            IDLE: begin
                if (in_valid && in_ready_q) begin
                    state_d    = data_in;
                    key_d      = key;
                    mode_d     = mode;
                    cnt_d      = 2'd0;
                    st_d       = RUN;
                    in_ready_d = 1'b0;
                end
            end
            RUN: begin
                state_d = round_out;
                cnt_d   = cnt_q + 2'd1;
                if (cnt_q == LAST) begin
                    st_d        = DONE;
                    out_valid_d = 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    st_d        = IDLE;
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                end
            end
            default: begin
                st_d        = IDLE;
                in_ready_d  = 1'b1;
                out_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st_q        <= IDLE;
            state_q     <= '0;
            key_q       <= '0;
            mode_q      <= 1'b0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            st_q        <= st_d;
            state_q     <= state_d;
            key_q       <= key_d;
            mode_q      <= mode_d;
            cnt_q       <= cnt_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign data_out  = state_q;

endmodule

// File: tb/tb_spn_round_ctrl.sv
// Bench for spn_round_ctrl: one instance per NUM_ROUNDS 1..4,
// reference cipher model with a scoreboard queue.
`timescale 1ns/1ps

module tb_spn_round_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid  [4];
    logic        in_ready  [4];
    logic [15:0] data_in   [4];
    logic [31:0] key       [4];
    logic        mode      [4];
    logic        out_valid [4];
    logic        out_ready [4];
    logic [15:0] data_out  [4];

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    logic [15:0] sbq[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        spn_round_ctrl #(.NUM_ROUNDS(g + 1)) u_dut (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (in_valid[g]),
            .in_ready  (in_ready[g]),
            .data_in   (data_in[g]),
            .key       (key[g]),
            .mode      (mode[g]),
            .out_valid (out_valid[g]),
            .out_ready (out_ready[g]),
            .data_out  (data_out[g])
        );
    end

    // Reference model
    function automatic logic [3:0] m_sb(input logic [3:0] v);
        logic [63:0] t;
        t = 64'hC56B_90AD_3EF8_4712;
        return t[63 - 4*v -: 4];
    endfunction

    function automatic logic [3:0] m_isb(input logic [3:0] y);
        logic [3:0] r;
        r = 4'h0;
        for (int v = 0; v < 16; v++)
            if (m_sb(4'(v)) == y) r = 4'(v);
        return r;
    endfunction

    function automatic logic [15:0] m_perm(input logic [15:0] x);
        logic [15:0] y;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                y[4*i+j] = x[4*j+i];
        return y;
    endfunction

    function automatic logic [15:0] m_sub(input logic [15:0] x, input bit inv);
        logic [15:0] y;
        for (int n = 0; n < 4; n++)
            y[4*n +: 4] = inv ? m_isb(x[4*n +: 4]) : m_sb(x[4*n +: 4]);
        return y;
    endfunction

    function automatic logic [15:0] m_rk(input logic [31:0] k, input int r);
        logic [31:0] s;
        s = k >> (16 - 4*r);
        return s[15:0];
    endfunction

    function automatic logic [15:0] model(input logic [15:0] d, input logic [31:0] k,
                                          input logic m, input int n);
        logic [15:0] x;
        x = d;
        if (!m) begin
            for (int r = 0; r < n; r++)
                x = m_perm(m_sub(x ^ m_rk(k, r), 1'b0));
        end else begin
            for (int r = n - 1; r >= 0; r--)
                x = m_sub(m_perm(x), 1'b1) ^ m_rk(k, r);
        end
        return x;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer one block, track latency, compare result, optionally stall the sink.
    task automatic run_block(input int idx, input logic [15:0] d, input logic [31:0] k,
                             input logic m, input int stall, output logic [15:0] res);
        int w;
        int lat;
        bit rdy_bad;
        logic [15:0] exp;
        logic [15:0] held;
        w = 0;
        while (!in_ready[idx] && w < 20) begin
            step();
            w++;
        end
        chk("in_ready_wait", 32'(in_ready[idx]), 32'd1);
        in_valid[idx] = 1'b1;
        data_in[idx]  = d;
        key[idx]      = k;
        mode[idx]     = m;
        sbq.push_back(model(d, k, m, idx + 1));
        step();
        in_valid[idx] = 1'b0;
        data_in[idx]  = 16'hDEAD;
        key[idx]      = 32'hBAD0_BAD0;
        mode[idx]     = ~m;
        lat = 1;
        rdy_bad = 1'b0;
        while (!out_valid[idx] && lat < 20) begin
            if (in_ready[idx]) rdy_bad = 1'b1;
            step();
            lat++;
        end
        chk("latency", 32'(lat), 32'(idx + 2));
        chk("in_ready_low_run", 32'(rdy_bad), 32'd0);
        exp = (sbq.size() > 0) ? sbq.pop_front() : 16'hxxxx;
        res = data_out[idx];
        chk("data_out", 32'(res), 32'(exp));
        held = res;
        for (int s = 0; s < stall; s++) begin
            step();
            chk("stall_valid", 32'(out_valid[idx]), 32'd1);
            chk("stall_data", 32'(data_out[idx]), 32'(held));
            chk("stall_in_ready", 32'(in_ready[idx]), 32'd0);
        end
        out_ready[idx] = 1'b1;
        chk("in_ready_same_cycle", 32'(in_ready[idx]), 32'd0);
        step();
        out_ready[idx] = 1'b0;
        chk("idle_in_ready", 32'(in_ready[idx]), 32'd1);
        chk("idle_out_valid", 32'(out_valid[idx]), 32'd0);
    endtask

    typedef struct {
        logic [15:0] d;
        logic [31:0] k;
        logic        m;
        logic [15:0] exp;
    } vec_t;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t tbl[6];
        logic [15:0] r1, r2;
        int last_acc;
        int nacc;
        bit seen_ov;

        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_valid[i]  = 1'b0;
            data_in[i]   = '0;
            key[i]       = '0;
            mode[i]      = 1'b0;
            out_ready[i] = 1'b0;
        end
        step();
        step();
        rst = 1'b0;
        chk("rst_in_ready", 32'(in_ready[2]), 32'd1);
        chk("rst_out_valid", 32'(out_valid[2]), 32'd0);
        chk("rst_data_out", 32'(data_out[2]), 32'h0);

        // Known-answer: one round of all-zero data and key.
        run_block(0, 16'h0000, 32'h0, 1'b0, 0, r1);
        chk("kat_n1_zero", 32'(r1), 32'h0000_FF00);

        // Accept, latency, then hold result for five cycles.
        run_block(2, 16'h1234, 32'hA5C3_0F96, 1'b0, 5, r1);
        run_block(2, r1, 32'hA5C3_0F96, 1'b1, 0, r2);
        chk("rt_1234", 32'(r2), 32'h1234);
        run_block(2, 16'h0000, 32'h0, 1'b0, 0, r1);
        run_block(2, r1, 32'h0, 1'b1, 0, r2);
        chk("rt_0000", 32'(r2), 32'h0000);
        run_block(2, 16'hFFFF, 32'h0, 1'b0, 0, r1);
        run_block(2, r1, 32'h0, 1'b1, 0, r2);
        chk("rt_ffff", 32'(r2), 32'hFFFF);

        tbl[0] = '{16'hABCD, 32'h0123_4567, 1'b0, 16'h0};
        tbl[1] = '{16'hABCD, 32'h0123_4567, 1'b1, 16'h0};
        tbl[2] = '{16'h8001, 32'hFFFF_FFFF, 1'b0, 16'h0};
        tbl[3] = '{16'h5A5A, 32'h8000_0001, 1'b1, 16'h0};
        tbl[4] = '{16'h0F0F, 32'hDEAD_BEEF, 1'b0, 16'h0};
        tbl[5] = '{16'hC3C3, 32'h1357_9BDF, 1'b1, 16'h0};
        for (int i = 0; i < 6; i++)
            tbl[i].exp = model(tbl[i].d, tbl[i].k, tbl[i].m, 3);
        for (int i = 0; i < 6; i++) begin
            run_block(2, tbl[i].d, tbl[i].k, tbl[i].m, 0, r1);
            chk("table", 32'(r1), 32'(tbl[i].exp));
        end

        // Reset in the second RUN cycle discards the block.
        in_valid[2] = 1'b1;
        data_in[2]  = 16'h7777;
        key[2]      = 32'h2468_ACE0;
        mode[2]     = 1'b0;
        step();
        in_valid[2] = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("midrun_rst_in_ready", 32'(in_ready[2]), 32'd1);
        chk("midrun_rst_out_valid", 32'(out_valid[2]), 32'd0);
        chk("midrun_rst_data", 32'(data_out[2]), 32'h0);
        seen_ov = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (out_valid[2]) seen_ov = 1'b1;
            step();
        end
        chk("midrun_no_valid", 32'(seen_ov), 32'd0);
        run_block(2, 16'h7777, 32'h2468_ACE0, 1'b0, 0, r1);

        // Continuous in_valid with changing data.
        last_acc = -1;
        nacc = 0;
        out_ready[2] = 1'b1;
        for (int c = 0; c < 60; c++) begin
            if (out_valid[2]) begin
                if (sbq.size() > 0)
                    chk("stream_data", 32'(data_out[2]), 32'(sbq.pop_front()));
                else
                    chk("stream_extra_out", 32'd1, 32'd0);
            end
            in_valid[2] = 1'b1;
            data_in[2]  = 16'($urandom);
            key[2]      = $urandom;
            mode[2]     = 1'($urandom);
            if (in_ready[2]) begin
                sbq.push_back(model(data_in[2], key[2], mode[2], 3));
                if (last_acc >= 0)
                    chk("stream_spacing", 32'(cyc - last_acc), 32'd5);
                last_acc = cyc;
                nacc++;
            end
            step();
        end
        in_valid[2] = 1'b0;
        for (int c = 0; c < 10 && sbq.size() > 0; c++) begin
            if (out_valid[2])
                chk("stream_drain", 32'(data_out[2]), 32'(sbq.pop_front()));
            step();
        end
        out_ready[2] = 1'b0;
        chk("stream_accepts", 32'(nacc), 32'd12);
        chk("stream_queue_empty", 32'(sbq.size()), 32'd0);
        sbq.delete();
        step();

        // Random round-trip sweep for NUM_ROUNDS 1, 2 and 4.
        for (int s = 0; s < 3; s++) begin
            int idx;
            idx = (s == 2) ? 3 : s;
            for (int i = 0; i < 1000; i++) begin
                logic [15:0] d;
                logic [31:0] k;
                d = 16'($urandom);
                k = $urandom;
                run_block(idx, d, k, 1'b0, 0, r1);
                run_block(idx, r1, k, 1'b1, 0, r2);
                chk("sweep_roundtrip", 32'(r2), 32'(d));
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
